// File: rtl/contador_ctrl_pkg.sv
// rtl/contador_ctrl_pkg.sv - counter mode codes and sequencer state encodings shared with contador
package contador_ctrl_pkg;

    localparam logic [1:0] COUNT_UP     = 2'b00;
    localparam logic [1:0] COUNT_DOWN   = 2'b01;
    localparam logic [1:0] COUNT_3_DOWN = 2'b10;
    localparam logic [1:0] CHARGE       = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/contador_cmd_fifo.sv
// rtl/contador_cmd_fifo.sv - synchronous command FIFO with full/empty flags and flush
module contador_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 50
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/contador_ctrl.sv
// rtl/contador_ctrl.sv - command sequencer driving contador; optional ABORT/ABORTED with CONTADOR_CTRL_ABORT_EN
module contador_ctrl
    import contador_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODE,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic [LEN_W-1:0] CMD_LEN,
`ifdef CONTADOR_CTRL_ABORT_EN
    input  logic             ABORT,
    output logic             ABORTED,
`endif
    input  logic             CNT_RCO,
    output logic             CNT_ENABLE,
    output logic [1:0]       CNT_MODO,
    output logic [WIDTH-1:0] CNT_D,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       RCO_CNT
);
    localparam int CW = 2 + WIDTH + LEN_W;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ready_en;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             abort_now;
    logic [CW-1:0]    head;
    logic [1:0]       cmd_mode;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       rco_cnt;

`ifdef CONTADOR_CTRL_ABORT_EN
    logic aborted;
    assign abort_now = ABORT;
    assign ABORTED   = aborted;
`else
    assign abort_now = 1'b0;
`endif

    // ready_en holds CMD_READY low until the first edge after reset release.
    assign CMD_READY = ready_en && !full;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = ((state == ST_IDLE) || (state == ST_DONE)) && !empty && !abort_now;

    contador_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (CW)
    ) u_fifo (
        .clk       (clk),
        .RESET     (RESET),
        .flush     (abort_now),
        .push      (push),
        .push_data ({CMD_MODE, CMD_DATA, CMD_LEN}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pop) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (abort_now || (cmd_mode == CHARGE) || (remaining == '0)) state_nxt = ST_DONE;
                else                                                         state_nxt = ST_RUN;
            end
            ST_RUN:  if (abort_now || (remaining == LEN_W'(1))) state_nxt = ST_DONE;
            ST_DONE: state_nxt = pop ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            ready_en  <= 1'b0;
            cmd_mode  <= '0;
            cmd_data  <= '0;
            remaining <= '0;
            rco_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            // remaining is loaded straight from the run length and counted down in RUN
            if (pop) begin
                {cmd_mode, cmd_data, remaining} <= head;
            end else if (state == ST_RUN) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (pop) begin
                rco_cnt <= '0;
            end else if ((state == ST_RUN) && CNT_RCO && (rco_cnt != 8'hFF)) begin
                rco_cnt <= rco_cnt + 8'd1;
            end
        end
    end

`ifdef CONTADOR_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) aborted <= 1'b0;
        else        aborted <= abort_now && ((state == ST_LOAD) || (state == ST_RUN));
    end
`endif

    assign CNT_ENABLE = (state == ST_LOAD) || (state == ST_RUN);
    assign CNT_MODO   = (state == ST_RUN) ? cmd_mode : CHARGE;
    assign CNT_D      = CNT_ENABLE ? cmd_data : '0;
    assign BUSY       = (state != ST_IDLE);
    assign DONE       = (state == ST_DONE);
    assign RCO_CNT    = rco_cnt;

endmodule

// File: tb/tb_contador_ctrl.sv
// tb/tb_contador_ctrl.sv - self-checking bench for contador_ctrl with a behavioural counter stand-in
module tb_contador_ctrl;
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [15:0] len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic [1:0]  CMD_MODE = 2'b00;
    logic [31:0] CMD_DATA = '0;
    logic [15:0] CMD_LEN = '0;
    logic        CMD_READY;
    logic        CNT_RCO;
    logic        CNT_ENABLE;
    logic [1:0]  CNT_MODO;
    logic [31:0] CNT_D;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  RCO_CNT;
`ifdef CONTADOR_CTRL_ABORT_EN
    logic        ABORT = 1'b0;
    logic        ABORTED;
`endif

    int   tests = 0;
    int   fails = 0;
    cmd_t exp_q[$];

    logic [31:0] q = '0;
    logic        rco_q = 1'b0;
    logic        rco_force = 1'b0;

    always #5 clk = ~clk;

    contador_ctrl #(.WIDTH(32), .DEPTH(4), .LEN_W(16)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_MODE   (CMD_MODE),
        .CMD_DATA   (CMD_DATA),
        .CMD_LEN    (CMD_LEN),
`ifdef CONTADOR_CTRL_ABORT_EN
        .ABORT      (ABORT),
        .ABORTED    (ABORTED),
`endif
        .CNT_RCO    (CNT_RCO),
        .CNT_ENABLE (CNT_ENABLE),
        .CNT_MODO   (CNT_MODO),
        .CNT_D      (CNT_D),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RCO_CNT    (RCO_CNT)
    );

    // Stand-in for contador: RCO is a registered pulse after a wrap.
    always @(posedge clk) begin
        if (CNT_ENABLE) begin
            case (CNT_MODO)
                2'b00: begin rco_q <= (q == 32'hFFFF_FFFF); q <= q + 32'd1; end
                2'b01: begin rco_q <= (q == 32'd0);         q <= q - 32'd1; end
                2'b10: begin rco_q <= (q < 32'd3);          q <= q - 32'd3; end
                default: begin rco_q <= 1'b0;               q <= CNT_D;     end
            endcase
        end else begin
            rco_q <= 1'b0;
        end
    end
    assign CNT_RCO = rco_q | rco_force;

    always @(posedge clk) begin
        if (RESET && CMD_VALID && CMD_READY) exp_q.push_back('{CMD_MODE, CMD_DATA, CMD_LEN});
    end

    function automatic logic [31:0] model_q(input cmd_t c);
        case (c.mode)
            2'b00:   return c.data + 32'(c.len);
            2'b01:   return c.data - 32'(c.len);
            2'b10:   return c.data - 32'(3 * int'(c.len));
            default: return c.data;
        endcase
    endfunction

    // Only wraps on the first len-1 steps produce an RCO inside RUN.
    function automatic int model_rco(input cmd_t c);
        longint steps;
        steps = (c.mode == 2'b11 || c.len < 16'd2) ? 0 : longint'(c.len) - 1;
        if (steps == 0) return 0;
        case (c.mode)
            2'b00:   return ((longint'(c.data) + steps) >= 64'h1_0000_0000) ? 1 : 0;
            2'b01:   return (longint'(c.data) < steps) ? 1 : 0;
            default: return (longint'(c.data) < 3 * steps) ? 1 : 0;
        endcase
    endfunction

    task automatic drive_cmd(input cmd_t c);
        int w = 0;
        CMD_VALID = 1'b1;
        CMD_MODE  = c.mode;
        CMD_DATA  = c.data;
        CMD_LEN   = c.len;
        while (CMD_READY !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        tests++;
        if (CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL push_accept: CMD_READY=%b, required 1 within 2000 cycles", CMD_READY);
        end
        @(negedge clk);
        CMD_VALID = 1'b0;
    endtask

    task automatic check_cmds(input int n);
        cmd_t c;
        int   wait_c;
        int   run;
        int   limit;
        bit   expect_now = 1'b0;
        for (int k = 0; k < n; k++) begin
            limit  = expect_now ? 0 : 400;
            wait_c = 0;
            while (!(CNT_ENABLE === 1'b1 && CNT_MODO === 2'b11) && wait_c < limit) begin
                @(negedge clk); wait_c++;
            end
            tests++;
            if (!(CNT_ENABLE === 1'b1 && CNT_MODO === 2'b11) || exp_q.size() == 0) begin
                fails++;
                $display("FAIL load_start cmd %0d: enable=%b modo=%b queued=%0d, required LOAD (immediate=%0b)",
                         k, CNT_ENABLE, CNT_MODO, exp_q.size(), expect_now);
                return;
            end
            c = exp_q.pop_front();
            tests++;
            if (CNT_D !== c.data || RCO_CNT !== 8'd0) begin
                fails++;
                $display("FAIL load_out cmd %0d: D=%h rco_cnt=%0d, required D=%h rco_cnt=0", k, CNT_D, RCO_CNT, c.data);
            end
            run = 0;
            @(negedge clk);
            while (CNT_ENABLE === 1'b1 && CNT_MODO !== 2'b11 && run < 1000) begin
                tests++;
                if (CNT_MODO !== c.mode || CNT_D !== c.data) begin
                    fails++;
                    $display("FAIL run_out cmd %0d: modo=%b D=%h, required modo=%b D=%h", k, CNT_MODO, CNT_D, c.mode, c.data);
                end
                run++;
                @(negedge clk);
            end
            tests++;
            if (DONE !== 1'b1 || CNT_ENABLE !== 1'b0 || run != ((c.mode == 2'b11) ? 0 : int'(c.len))) begin
                fails++;
                $display("FAIL run_len cmd %0d: run=%0d done=%b enable=%b, required run=%0d done=1 enable=0",
                         k, run, DONE, CNT_ENABLE, (c.mode == 2'b11) ? 0 : int'(c.len));
            end
            tests++;
            if (q !== model_q(c) || RCO_CNT !== 8'(model_rco(c))) begin
                fails++;
                $display("FAIL result cmd %0d: Q=%h rco_cnt=%0d, required Q=%h rco_cnt=%0d",
                         k, q, RCO_CNT, model_q(c), model_rco(c));
            end
            expect_now = (exp_q.size() > 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (CMD_READY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CNT_ENABLE !== 1'b0 ||
            CNT_MODO !== 2'b11 || CNT_D !== 32'd0 || RCO_CNT !== 8'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b en=%b modo=%b D=%h rco=%0d, required 0 0 0 0 11 0 0",
                     CMD_READY, BUSY, DONE, CNT_ENABLE, CNT_MODO, CNT_D, RCO_CNT);
        end
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        tests++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", CMD_READY, BUSY);
        end
    endtask

    task automatic test_directed;
        cmd_t tbl[4];
        tbl[0] = '{2'b00, 32'h0000_000A, 16'd5};
        tbl[1] = '{2'b11, 32'hDEAD_BEEF, 16'd7};
        tbl[2] = '{2'b00, 32'h0000_1234, 16'd0};
        tbl[3] = '{2'b00, 32'hFFFF_FFFE, 16'd4};
        for (int i = 0; i < 4; i++) begin
            fork
                drive_cmd(tbl[i]);
                check_cmds(1);
            join
            tests++;
            if (BUSY !== 1'b0 || DONE !== 1'b0 || RCO_CNT !== 8'(model_rco(tbl[i]))) begin
                fails++;
                $display("FAIL directed_after %0d: busy=%b done=%b rco_cnt=%0d, required 0 0 %0d",
                         i, BUSY, DONE, RCO_CNT, model_rco(tbl[i]));
            end
        end
    endtask

    task automatic test_back_to_back;
        cmd_t c0 = '{2'b00, 32'd100, 16'd12};
        cmd_t c5 = '{2'b01, 32'd1, 16'd3};
        cmd_t ci;
        int   w = 0;
        fork
            begin
                drive_cmd(c0);
                while (BUSY !== 1'b1 && w < 20) begin @(negedge clk); w++; end
                for (int i = 1; i <= 4; i++) begin
                    ci = '{2'($urandom_range(0, 3)), 32'($urandom), 16'($urandom_range(0, 4))};
                    CMD_VALID = 1'b1; CMD_MODE = ci.mode; CMD_DATA = ci.data; CMD_LEN = ci.len;
                    tests++;
                    if (CMD_READY !== 1'b1) begin
                        fails++;
                        $display("FAIL b2b_ready %0d: ready=%b, required 1", i, CMD_READY);
                    end
                    @(negedge clk);
                end
                CMD_MODE = c5.mode; CMD_DATA = c5.data; CMD_LEN = c5.len;
                tests++;
                if (CMD_READY !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_full: ready=%b after 4 pushes, required 0", CMD_READY);
                end
                w = 0;
                while (CMD_READY !== 1'b1 && w < 100) begin @(negedge clk); w++; end
                tests++;
                if (!(CMD_READY === 1'b1 && CNT_ENABLE === 1'b1 && CNT_MODO === 2'b11)) begin
                    fails++;
                    $display("FAIL b2b_held: ready=%b en=%b modo=%b, required ready=1 during LOAD after pop",
                             CMD_READY, CNT_ENABLE, CNT_MODO);
                end
                @(negedge clk);
                CMD_VALID = 1'b0;
            end
            check_cmds(6);
        join
    endtask

    task automatic test_random;
        cmd_t cmds[25];
        for (int i = 0; i < 25; i++) begin
            cmds[i].mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cmds[i].data = 32'($urandom_range(0, 6));
                1:       cmds[i].data = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
                default: cmds[i].data = 32'($urandom);
            endcase
            cmds[i].len = 16'($urandom_range(0, 9));
        end
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    drive_cmd(cmds[i]);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            check_cmds(25);
        join
    endtask

    task automatic test_saturate;
        cmd_t c;
        int   w;
        int   lens[2] = '{200, 300};
        int   want[2] = '{200, 255};
        rco_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c = '{2'b00, 32'd0, 16'(lens[i])};
            drive_cmd(c);
            w = 0;
            while (DONE !== 1'b1 && w < 400) begin @(negedge clk); w++; end
            tests++;
            if (DONE !== 1'b1 || RCO_CNT !== 8'(want[i])) begin
                fails++;
                $display("FAIL saturate len %0d: done=%b rco_cnt=%0d, required done=1 rco_cnt=%0d", lens[i], DONE, RCO_CNT, want[i]);
            end
            @(negedge clk);
            tests++;
            if (RCO_CNT !== 8'(want[i])) begin
                fails++;
                $display("FAIL saturate_hold len %0d: rco_cnt=%0d, required %0d", lens[i], RCO_CNT, want[i]);
            end
        end
        rco_force = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run;
        int w = 0;
        drive_cmd('{2'b00, 32'd7, 16'd30});
        drive_cmd('{2'b01, 32'd9, 16'd3});
        drive_cmd('{2'b10, 32'd9, 16'd3});
        while (!(CNT_ENABLE === 1'b1 && CNT_MODO !== 2'b11) && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        #2;
        RESET = 1'b0;
        #1;
        tests++;
        if (CMD_READY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CNT_ENABLE !== 1'b0 ||
            CNT_MODO !== 2'b11 || CNT_D !== 32'd0 || RCO_CNT !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_run: ready=%b busy=%b done=%b en=%b modo=%b D=%h rco=%0d, required 0 0 0 0 11 0 0",
                     CMD_READY, BUSY, DONE, CNT_ENABLE, CNT_MODO, CNT_D, RCO_CNT);
        end
        exp_q.delete();
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        tests++;
        if (CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: ready=%b, required 1", CMD_READY);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (BUSY !== 1'b0 || CNT_ENABLE !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_flushed: busy=%b en=%b, required 0 0 (queue discarded)", BUSY, CNT_ENABLE);
        end
    endtask

`ifdef CONTADOR_CTRL_ABORT_EN
    task automatic test_abort;
        int w = 0;
        drive_cmd('{2'b00, 32'd50, 16'd10});
        drive_cmd('{2'b01, 32'd5, 16'd2});
        drive_cmd('{2'b01, 32'd6, 16'd2});
        while (!(CNT_ENABLE === 1'b1 && CNT_MODO !== 2'b11) && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        tests++;
        if (DONE !== 1'b1 || ABORTED !== 1'b1) begin
            fails++;
            $display("FAIL abort_done: done=%b aborted=%b, required 1 1", DONE, ABORTED);
        end
        @(negedge clk);
        tests++;
        if (BUSY !== 1'b0 || ABORTED !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b aborted=%b, required 0 0", BUSY, ABORTED);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL abort_flushed: busy=%b ready=%b, required 0 1", BUSY, CMD_READY);
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid_run();
`ifdef CONTADOR_CTRL_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
